// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit: op codes, HI/LO write codes, FSM states.
// Codes 5-7 only take effect when MD_MADD_EN is defined.
package md_pkg;

   localparam logic [2:0] md_none  = 3'd0;
   localparam logic [2:0] md_mult  = 3'd1;
   localparam logic [2:0] md_multu = 3'd2;
   localparam logic [2:0] md_div   = 3'd3;
   localparam logic [2:0] md_divu  = 3'd4;
   localparam logic [2:0] md_madd  = 3'd5;
   localparam logic [2:0] md_maddu = 3'd6;
   localparam logic [2:0] md_msub  = 3'd7;

   localparam logic [1:0] md_we_hi = 2'd1;
   localparam logic [1:0] md_we_lo = 2'd2;

   typedef enum logic {
      StIdle,
      StBusy
   } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational result generator for mult/div (and madd/maddu/msub under MD_MADD_EN).
// valid_o is low for codes that the current build treats as no-ops.
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] d1_i,
   input  logic [31:0] d2_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic        valid_o,
   output logic [31:0] pend_hi_o,
   output logic [31:0] pend_lo_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] acc;
   logic        sgn_div;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   // Low 64 bits of a product of sign-extended operands equal the signed product.
   assign prod_s = {{32{d1_i[31]}}, d1_i} * {{32{d2_i[31]}}, d2_i};
   assign prod_u = {32'd0, d1_i} * {32'd0, d2_i};
   assign acc    = {hi_i, lo_i};

   // One unsigned divider on magnitudes; signs restored afterwards. Zero divisor is masked.
   assign sgn_div  = (op_i == md_div);
   assign dvd      = (sgn_div && d1_i[31]) ? (32'd0 - d1_i) : d1_i;
   assign dvs      = (d2_i == 32'd0) ? 32'd1 :
                     ((sgn_div && d2_i[31]) ? (32'd0 - d2_i) : d2_i);
   assign quot     = dvd / dvs;
   assign rem      = dvd % dvs;
   assign quot_fix = (sgn_div && (d1_i[31] ^ d2_i[31])) ? (32'd0 - quot) : quot;
   assign rem_fix  = (sgn_div && d1_i[31]) ? (32'd0 - rem) : rem;

   always_comb begin
      valid_o                = 1'b1;
      {pend_hi_o, pend_lo_o} = acc;
      case (op_i)
         md_mult:  {pend_hi_o, pend_lo_o} = prod_s;
         md_multu: {pend_hi_o, pend_lo_o} = prod_u;
         md_div, md_divu: begin
            if (d2_i != 32'd0) begin
               pend_hi_o = rem_fix;
               pend_lo_o = quot_fix;
            end
         end
`ifdef MD_MADD_EN
         md_madd:  {pend_hi_o, pend_lo_o} = acc + prod_s;
         md_maddu: {pend_hi_o, pend_lo_o} = acc + prod_u;
         md_msub:  {pend_hi_o, pend_lo_o} = acc - prod_s;
`endif
         default:  valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; busy for MULT_CYCLES or DIV_CYCLES.
// Optional madd/maddu/msub support is enabled by defining MD_MADD_EN.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   input  logic [2:0]  multctrl,
   input  logic        start,
   input  logic [1:0]  we,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   md_state_e   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        calc_valid;
   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic        is_div;

   md_calc u_calc (
      .op_i      (multctrl),
      .d1_i      (D1),
      .d2_i      (D2),
      .hi_i      (hi_q),
      .lo_i      (lo_q),
      .valid_o   (calc_valid),
      .pend_hi_o (calc_hi),
      .pend_lo_o (calc_lo)
   );

   assign is_div = (multctrl == md_div) || (multctrl == md_divu);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (calc_valid) begin
                  pend_hi_d = calc_hi;
                  pend_lo_d = calc_lo;
                  cnt_d     = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                  state_d   = StBusy;
               end
            end else begin
               if (we == md_we_hi) hi_d = D1;
               if (we == md_we_lo) lo_d = D1;
            end
         end
         StBusy: begin
            cnt_d = cnt_q - CntW'(1);
            // Counter holds N on the first busy cycle, so 1 marks the last one.
            if (cnt_q == CntW'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == StBusy);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
